// File: rtl/gbf_pingpong_ctrl.sv
// ----------------------------------------------------------------------------
// gbf_pingpong_ctrl
//   Sequences one double-buffered global buffer (bank 1 / bank 2) holding
//   either activations or weights.  The loader fills the empty bank through
//   port a, while the array reads the full bank through port b.  Each tile is
//   replayed cfg_reuse_i times and then the bank is released back to the
//   loader.
//
// Ports
//   clk_i              clock, all state on the rising edge
//   rst_n_i            asynchronous active-low reset
//   start_i            pulse: IDLE -> RUN, cfg_reuse_i sampled this cycle
//   finish_i           pulse: synchronous abort to IDLE, wins over start_i
//   cfg_reuse_i        reads of each tile before release (0 behaves as 1)
//   ld_valid_i         loader presents a line
//   ld_last_i          last line of the tile (qualified by ld_valid_i)
//   ld_ready_o         line accepted when ld_valid_i & ld_ready_o
//   en1a_o, we1a_o     bank 1 port-a enable / write enable
//   en2a_o, we2a_o     bank 2 port-a enable / write enable
//   addra_o            port-a write address (shared by both banks)
//   gbf1_need_data_o   bank 1 empty and next to be filled
//   gbf2_need_data_o   bank 2 empty and next to be filled
//   rd_req_i           array requests the next line
//   data_avail_o       bank under read is full, rd_req_i is accepted
//   en1b_o, en2b_o     bank port-b read enables
//   addrb_o            port-b read address
//   rd_valid_o         bank read data valid (one cycle after accept)
//   rd_bank_o          bank under read (0 = bank 1, 1 = bank 2)
//   tile_done_o        one-cycle pulse after a bank is released
// ----------------------------------------------------------------------------
module gbf_pingpong_ctrl #(
    parameter int unsigned GBF_DATA_BITWIDTH = 512,
    parameter int unsigned GBF_ADDR_BITWIDTH = 5,
    parameter int unsigned GBF_DEPTH         = 32,
    parameter int unsigned REUSE_BITWIDTH    = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    input  logic                         finish_i,
    input  logic [REUSE_BITWIDTH-1:0]    cfg_reuse_i,
    input  logic                         ld_valid_i,
    input  logic                         ld_last_i,
    output logic                         ld_ready_o,
    output logic                         en1a_o,
    output logic                         we1a_o,
    output logic                         en2a_o,
    output logic                         we2a_o,
    output logic [GBF_ADDR_BITWIDTH-1:0] addra_o,
    output logic                         gbf1_need_data_o,
    output logic                         gbf2_need_data_o,
    input  logic                         rd_req_i,
    output logic                         data_avail_o,
    output logic                         en1b_o,
    output logic                         en2b_o,
    output logic [GBF_ADDR_BITWIDTH-1:0] addrb_o,
    output logic                         rd_valid_o,
    output logic                         rd_bank_o,
    output logic                         tile_done_o
);

    localparam int unsigned AB = GBF_ADDR_BITWIDTH;
    localparam int unsigned RB = REUSE_BITWIDTH;
    localparam logic [AB-1:0] LAST_ADDR = AB'(GBF_DEPTH - 1);

    // The line width only documents the bank; reject nonsensical geometry.
    if (GBF_DATA_BITWIDTH == 0 || GBF_DEPTH == 0 || GBF_DEPTH > (1 << AB)) begin : g_cfg_check
        $error("gbf_pingpong_ctrl: invalid bank geometry");
    end

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    full_q, full_d;        // bit 0 = bank 1, bit 1 = bank 2
    logic          wsel_q, wsel_d;
    logic          rsel_q, rsel_d;
    logic [AB-1:0] waddr_q, waddr_d;
    logic [AB-1:0] raddr_q, raddr_d;
    logic [AB:0]   len1_q, len1_d;        // one extra bit: a tile may be GBF_DEPTH long
    logic [AB:0]   len2_q, len2_d;
    logic [RB-1:0] reuse_q, reuse_d;
    logic [RB-1:0] reuse_cnt_q, reuse_cnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic          tile_done_q, tile_done_d;

    logic          run;
    logic          need1, need2;
    logic          wr_acc, wr_end;
    logic          avail, rd_acc, rd_wrap, last_pass, rel;
    logic [AB:0]   len_cur;

    // ------------------------------------------------------------------
    // Handshake decode, purely from registered state
    // ------------------------------------------------------------------
    always_comb begin
        run       = (state_q == ST_RUN);
        need1     = run & ~wsel_q & ~full_q[0];
        need2     = run &  wsel_q & ~full_q[1];
        wr_acc    = ld_valid_i & (wsel_q ? need2 : need1);
        wr_end    = wr_acc & (ld_last_i | (waddr_q == LAST_ADDR));
        avail     = run & (rsel_q ? full_q[1] : full_q[0]);
        rd_acc    = rd_req_i & avail;
        len_cur   = rsel_q ? len2_q : len1_q;
        rd_wrap   = (({1'b0, raddr_q} + (AB+1)'(1)) == len_cur);
        last_pass = (({1'b0, reuse_cnt_q} + (RB+1)'(1)) == {1'b0, reuse_q});
        rel       = rd_acc & rd_wrap & last_pass;
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        len1_d      = len1_q;
        len2_d      = len2_q;
        reuse_d     = reuse_q;
        reuse_cnt_d = reuse_cnt_q;
        // A read issued in the finish cycle still drives the bank, but its
        // data is never flagged valid.
        rd_valid_d  = rd_acc & ~finish_i;
        tile_done_d = rel & ~finish_i;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !finish_i) begin
                    state_d = ST_RUN;
                    reuse_d = (cfg_reuse_i == '0) ? RB'(1) : cfg_reuse_i;
                end
            end
            ST_RUN: begin
                if (finish_i) begin
                    state_d     = ST_IDLE;
                    full_d      = '0;
                    wsel_d      = 1'b0;
                    rsel_d      = 1'b0;
                    waddr_d     = '0;
                    raddr_d     = '0;
                    len1_d      = '0;
                    len2_d      = '0;
                    reuse_cnt_d = '0;
                end else begin
                    // Fill and release always touch different banks, so
                    // both may update full_d in the same cycle.
                    if (wr_acc) begin
                        if (wr_end) begin
                            if (wsel_q) len2_d = {1'b0, waddr_q} + (AB+1)'(1);
                            else        len1_d = {1'b0, waddr_q} + (AB+1)'(1);
                            full_d[wsel_q] = 1'b1;
                            waddr_d        = '0;
                            wsel_d         = ~wsel_q;
                        end else begin
                            waddr_d = waddr_q + AB'(1);
                        end
                    end
                    if (rd_acc) begin
                        if (rd_wrap) begin
                            raddr_d = '0;
                            if (last_pass) begin
                                full_d[rsel_q] = 1'b0;
                                rsel_d         = ~rsel_q;
                                reuse_cnt_d    = '0;
                            end else begin
                                reuse_cnt_d = reuse_cnt_q + RB'(1);
                            end
                        end else begin
                            raddr_d = raddr_q + AB'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            full_q      <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            len1_q      <= '0;
            len2_q      <= '0;
            reuse_q     <= '0;
            reuse_cnt_q <= '0;
            rd_valid_q  <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            len1_q      <= len1_d;
            len2_q      <= len2_d;
            reuse_q     <= reuse_d;
            reuse_cnt_q <= reuse_cnt_d;
            rd_valid_q  <= rd_valid_d;
            tile_done_q <= tile_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        gbf1_need_data_o = need1;
        gbf2_need_data_o = need2;
        ld_ready_o       = wsel_q ? need2 : need1;
        en1a_o           = wr_acc & ~wsel_q;
        we1a_o           = wr_acc & ~wsel_q;
        en2a_o           = wr_acc &  wsel_q;
        we2a_o           = wr_acc &  wsel_q;
        addra_o          = waddr_q;
        data_avail_o     = avail;
        en1b_o           = rd_acc & ~rsel_q;
        en2b_o           = rd_acc &  rsel_q;
        addrb_o          = raddr_q;
        rd_valid_o       = rd_valid_q;
        rd_bank_o        = rsel_q;
        tile_done_o      = tile_done_q;
    end

endmodule

// File: tb/tb_gbf_pingpong_ctrl.sv
module tb_gbf_pingpong_ctrl;

    localparam int unsigned AB    = 5;
    localparam int unsigned RB    = 8;
    localparam int unsigned DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, finish = 1'b0;
    logic [RB-1:0] cfg_reuse = '0;
    logic          ld_valid = 1'b0, ld_last = 1'b0, rd_req = 1'b0;
    logic          ld_ready, en1a, we1a, en2a, we2a, gbf1_nd, gbf2_nd;
    logic          data_avail, en1b, en2b, rd_valid, rd_bank, tile_done;
    logic [AB-1:0] addra, addrb;

    gbf_pingpong_ctrl #(
        .GBF_DATA_BITWIDTH (512),
        .GBF_ADDR_BITWIDTH (AB),
        .GBF_DEPTH         (DEPTH),
        .REUSE_BITWIDTH    (RB)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .start_i          (start),
        .finish_i         (finish),
        .cfg_reuse_i      (cfg_reuse),
        .ld_valid_i       (ld_valid),
        .ld_last_i        (ld_last),
        .ld_ready_o       (ld_ready),
        .en1a_o           (en1a),
        .we1a_o           (we1a),
        .en2a_o           (en2a),
        .we2a_o           (we2a),
        .addra_o          (addra),
        .gbf1_need_data_o (gbf1_nd),
        .gbf2_need_data_o (gbf2_nd),
        .rd_req_i         (rd_req),
        .data_avail_o     (data_avail),
        .en1b_o           (en1b),
        .en2b_o           (en2b),
        .addrb_o          (addrb),
        .rd_valid_o       (rd_valid),
        .rd_bank_o        (rd_bank),
        .tile_done_o      (tile_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Expected per-cycle view:
    // flags = {need1, need2, ready, avail, rd_bank, en1a, we1a, en2a, we2a, en1b, en2b}
    typedef struct {
        int unsigned   stamp;
        logic [10:0]   flags;
        logic [AB-1:0] addra;
        logic [AB-1:0] addrb;
    } stat_t;

    stat_t       sq[$];
    int unsigned vq[$];   // cycles in which rd_valid must be high
    int unsigned tq[$];   // cycles in which tile_done must be high

    // Reference model: ordered list of full tiles, each replayed as a flat
    // sequence of reuse*len line reads.
    typedef struct {
        bit          bank;
        int unsigned len;
    } tile_t;

    bit          m_run;
    int unsigned m_reuse;
    bit          m_wbank, m_rbank;
    int unsigned m_wcount;
    int unsigned m_pos;
    tile_t       tiles[$];

    function automatic bit m_full(input bit b);
        foreach (tiles[i]) if (tiles[i].bank == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        m_run = 0; m_reuse = 1; m_wbank = 0; m_rbank = 0;
        m_wcount = 0; m_pos = 0; tiles.delete();
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic step(input bit st, input bit fin, input int unsigned cfg,
                        input bit lv, input bit ll, input bit rq);
        bit          need1, need2, ready, avail, wacc, racc, rel;
        int unsigned len;
        stat_t       e;
        start = st; finish = fin; cfg_reuse = cfg[RB-1:0];
        ld_valid = lv; ld_last = ll; rd_req = rq;

        need1 = m_run && m_wbank == 1'b0 && !m_full(1'b0);
        need2 = m_run && m_wbank == 1'b1 && !m_full(1'b1);
        ready = m_wbank ? need2 : need1;
        avail = m_run && tiles.size() > 0;
        wacc  = lv && ready;
        racc  = rq && avail;
        len   = avail ? tiles[0].len : 1;
        rel   = racc && (m_pos == m_reuse * len - 1);

        e.stamp = cyc;
        e.flags = {need1, need2, ready, avail, m_rbank,
                   wacc && !m_wbank, wacc && !m_wbank, wacc && m_wbank, wacc && m_wbank,
                   racc && !m_rbank, racc && m_rbank};
        e.addra = AB'(m_wcount);
        e.addrb = AB'(m_pos % len);
        sq.push_back(e);
        if (racc && !fin) vq.push_back(cyc + 1);
        if (rel && !fin)  tq.push_back(cyc + 1);

        if (m_run) begin
            if (fin) begin
                model_clear();
            end else begin
                if (racc) begin
                    if (rel) begin
                        void'(tiles.pop_front());
                        m_pos   = 0;
                        m_rbank = ~m_rbank;
                    end else begin
                        m_pos++;
                    end
                end
                if (wacc) begin
                    if (ll || m_wcount == DEPTH - 1) begin
                        tiles.push_back('{bank: m_wbank, len: m_wcount + 1});
                        m_wcount = 0;
                        m_wbank  = ~m_wbank;
                    end else begin
                        m_wcount++;
                    end
                end
            end
        end else if (st && !fin) begin
            m_run   = 1;
            m_reuse = (cfg[RB-1:0] == 0) ? 1 : int'(cfg[RB-1:0]);
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int unsigned n, input bit with_last);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 1, with_last && (i == n - 1), 0);
    endtask

    task automatic reads(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
    endtask

    // Asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        logic [29:0] outs;
        start = 0; finish = 0; ld_valid = 0; ld_last = 0; rd_req = 0;
        rst_n = 1'b0;
        #2;
        outs = {ld_ready, en1a, we1a, en2a, we2a, addra, gbf1_nd, gbf2_nd, data_avail,
                en1b, en2b, addrb, rd_valid, rd_bank, tile_done};
        checks++;
        if (outs != '0) begin
            errors++;
            $display("FAIL reset_outputs_%s act=%h exp=0", tag, outs);
        end
        sq.delete(); vq.delete(); tq.delete();
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard.
    stat_t       mon_e;
    logic [10:0] mon_act;
    bit          mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                mon_e   = sq.pop_front();
                mon_act = {gbf1_nd, gbf2_nd, ld_ready, data_avail, rd_bank,
                           en1a, we1a, en2a, we2a, en1b, en2b};
                checks++;
                if (mon_e.stamp != cyc || mon_act != mon_e.flags) begin
                    errors++;
                    $display("FAIL status cyc=%0d stamp=%0d act=%b exp=%b",
                             cyc, mon_e.stamp, mon_act, mon_e.flags);
                end
                if (mon_e.flags[6] || mon_e.flags[4]) begin
                    checks++;
                    if (addra != mon_e.addra) begin
                        errors++;
                        $display("FAIL addra cyc=%0d act=%0d exp=%0d", cyc, addra, mon_e.addra);
                    end
                end
                if (mon_e.flags[1] || mon_e.flags[0]) begin
                    checks++;
                    if (addrb != mon_e.addrb) begin
                        errors++;
                        $display("FAIL addrb cyc=%0d act=%0d exp=%0d", cyc, addrb, mon_e.addrb);
                    end
                end
            end
            mon_exp = (vq.size() > 0 && vq[0] == cyc);
            if (mon_exp) void'(vq.pop_front());
            checks++;
            if (rd_valid !== mon_exp) begin
                errors++;
                $display("FAIL rd_valid cyc=%0d act=%b exp=%b", cyc, rd_valid, mon_exp);
            end
            mon_exp = (tq.size() > 0 && tq[0] == cyc);
            if (mon_exp) void'(tq.pop_front());
            checks++;
            if (tile_done !== mon_exp) begin
                errors++;
                $display("FAIL tile_done cyc=%0d act=%b exp=%b", cyc, tile_done, mon_exp);
            end
            checks++;
            if ((en1a && en1b) || (en2a && en2b)) begin
                errors++;
                $display("FAIL bank_conflict cyc=%0d act=%b%b%b%b exp=no_same_bank",
                         cyc, en1a, en1b, en2a, en2b);
            end
        end
    end

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        do_reset("init");

        // T1: reset in the middle of a fill, then no requests until start
        step(1, 0, 1, 0, 0, 0);
        load(2, 0);
        do_reset("midfill");
        idle(3);

        // T2: single tile of 4 lines, reuse 1
        step(1, 0, 1, 0, 0, 0);
        load(4, 1);
        idle(1);
        reads(4);
        idle(2);

        // T3: reuse 3 on a 2-line tile, bank 2 filled meanwhile
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0);
        load(2, 1);
        load(2, 1);
        idle(1);
        reads(6);
        idle(2);

        // T4: forced tile end on bank 2 while bank 1 is being read
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        load(8, 1);
        for (int unsigned i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0, i < 8);
        idle(1);
        reads(DEPTH);
        idle(2);

        // T5: both banks full -> loader stalled; reads with nothing available
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        load(3, 1);
        load(3, 1);
        load(4, 0);
        reads(9);
        idle(2);

        // T6: abort during the second of three passes, then restart
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0, 0);
        load(2, 1);
        reads(3);
        step(0, 1, 0, 0, 0, 1);
        idle(2);
        step(1, 0, 1, 0, 0, 0);
        load(2, 1);
        reads(3);
        idle(2);

        // Randomised traffic
        for (int unsigned i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 3),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 6);
        end

        step(0, 1, 0, 0, 0, 0);
        idle(3);
        @(negedge clk);
        checks++;
        if (sq.size() != 0 || vq.size() != 0 || tq.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d/%0d/%0d exp=0/0/0", sq.size(), vq.size(), tq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
